// File: rtl/display_timing_gen.sv
// ---------------------------------------------------------------------------
// display_timing_gen
//
// Raster timing for the pixel painters (road, track, lines, car sprites).
// A clock divider produces a pixel-rate strobe from clk. The strobe advances
// raw column/row counters through the full 640x480@60 VGA frame. The block
// also derives the video-active and sync flags, and an optional clk-cycle
// delay line on those flags lines them up with registered pixel colour.
//
// Ports
//   clk         in   system clock (100 MHz)
//   reset       in   synchronous, active-high
//   pix_en      out  one-clk strobe, once per CLK_DIV clocks
//   pix_col     out  current column, 0..H_TOTAL-1 (raw, not clamped)
//   pix_row     out  current row,    0..V_TOTAL-1 (raw, not clamped)
//   video_on    out  visible-pixel flag, delayed PIPE_DLY clk
//   horiz_sync  out  horizontal sync, delayed PIPE_DLY clk
//   vert_sync   out  vertical sync, delayed PIPE_DLY clk
//   frame_tick  out  one-clk pulse when the counters wrap to (0,0)
// ---------------------------------------------------------------------------
module display_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int PIPE_DLY = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_en,
    output logic [9:0] pix_col,
    output logic [9:0] pix_row,
    output logic       video_on,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       frame_tick
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ON  = (SYNC_POL != 0);
    localparam logic       SYNC_OFF = ~SYNC_ON;

    logic [3:0] div_q, div_d;
    logic       pix_en_q, pix_en_d;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       frame_tick_q, frame_tick_d;
    logic       vid_q, vid_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       col_wrap, row_wrap;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        // Strobe is registered off the next divider value so that it is high
        // exactly while div_q == CLK_DIV-1 (and permanently with CLK_DIV = 1).
        pix_en_d = (div_d == DIV_LAST);

        col_wrap     = (col_q == H_LAST);
        row_wrap     = (row_q == V_LAST);
        col_d        = col_q;
        row_d        = row_q;
        frame_tick_d = 1'b0;
        if (pix_en_q) begin
            col_d = col_wrap ? 10'd0 : col_q + 10'd1;
            if (col_wrap) begin
                row_d        = row_wrap ? 10'd0 : row_q + 10'd1;
                frame_tick_d = row_wrap;
            end
        end

        // Flags come from the next counter values so they register in step
        // with the counters themselves.
        vid_d = (col_d < H_ACT) && (row_d < V_ACT);
        hs_d  = ((col_d >= HS_FIRST) && (col_d <= HS_END)) ? SYNC_ON : SYNC_OFF;
        vs_d  = ((row_d >= VS_FIRST) && (row_d <= VS_END)) ? SYNC_ON : SYNC_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q        <= 4'd0;
            pix_en_q     <= 1'b0;
            col_q        <= 10'd0;
            row_q        <= 10'd0;
            frame_tick_q <= 1'b0;
            vid_q        <= 1'b0;
            hs_q         <= SYNC_OFF;
            vs_q         <= SYNC_OFF;
        end else begin
            div_q        <= div_d;
            pix_en_q     <= pix_en_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_tick_q <= frame_tick_d;
            vid_q        <= vid_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
        end
    end

    // Delay line runs every clk; it aligns with downstream colour registers,
    // not with the pixel strobe.
    if (PIPE_DLY == 0) begin : g_no_dly
        assign video_on   = vid_q;
        assign horiz_sync = hs_q;
        assign vert_sync  = vs_q;
    end else begin : g_dly
        logic [PIPE_DLY-1:0] vid_pipe_q;
        logic [PIPE_DLY-1:0] hs_pipe_q;
        logic [PIPE_DLY-1:0] vs_pipe_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                vid_pipe_q <= '0;
                hs_pipe_q  <= {PIPE_DLY{SYNC_OFF}};
                vs_pipe_q  <= {PIPE_DLY{SYNC_OFF}};
            end else begin
                vid_pipe_q[0] <= vid_q;
                hs_pipe_q[0]  <= hs_q;
                vs_pipe_q[0]  <= vs_q;
                for (int i = 1; i < PIPE_DLY; i++) begin
                    vid_pipe_q[i] <= vid_pipe_q[i-1];
                    hs_pipe_q[i]  <= hs_pipe_q[i-1];
                    vs_pipe_q[i]  <= vs_pipe_q[i-1];
                end
            end
        end

        assign video_on   = vid_pipe_q[PIPE_DLY-1];
        assign horiz_sync = hs_pipe_q[PIPE_DLY-1];
        assign vert_sync  = vs_pipe_q[PIPE_DLY-1];
    end

    assign pix_en     = pix_en_q;
    assign pix_col    = col_q;
    assign pix_row    = row_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/display_timing_gen.md
# display_timing_gen

Display timing generator that produces the raster scan consumed by the pixel-painting blocks: road, track, white lines, and car sprites. Runs on the 100 MHz system clock with an internal pixel-rate enable. Generates 640x480 @ 60 Hz VGA column/row counters, sync pulses, a video-active flag and a once-per-frame tick for animation logic. Sync and video-active outputs can be delayed in clock cycles so they line up with the registered pixel colour from downstream painters.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz / 4 = 25 MHz); legal 1..8
- H_ACTIVE, 640: visible columns
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: horizontal sync width
- H_BP, 48: horizontal back porch; H_TOTAL = 800
- V_ACTIVE, 480: visible rows
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vertical sync width
- V_BP, 33: vertical back porch; V_TOTAL = 525
- SYNC_POL, 0: asserted sync level (0 = active-low)
- PIPE_DLY, 1: clk-cycle delay on horiz_sync/vert_sync/video_on; legal 0..4

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- pix_en  out  1  one-clk strobe, once per CLK_DIV clocks
- pix_col  out  10  current column, 0..H_TOTAL-1
- pix_row  out  10  current row, 0..V_TOTAL-1
- video_on  out  1  high while pixel is visible (delayed PIPE_DLY)
- horiz_sync  out  1  horizontal sync (delayed PIPE_DLY)
- vert_sync  out  1  vertical sync (delayed PIPE_DLY)
- frame_tick  out  1  one-clk pulse at start of each frame

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = 1 when div_cnt == CLK_DIV-1. With CLK_DIV = 1, pix_en is held high.
- Column/row advance on a clk where pix_en = 1:
  - pix_col increments, wrapping H_TOTAL-1 -> 0.
  - On column wrap, pix_row increments, wrapping V_TOTAL-1 -> 0.
  - The counters are raw and are not clamped in blanking; consumers must gate with video_on.
- Undelayed flags are registered and derived from the next counter values, so they are valid in the same cycle as the counters:
  - vid = (col < H_ACTIVE) && (row < V_ACTIVE)
  - hs = SYNC_POL when col in [656, 751]; ~SYNC_POL otherwise
  - vs = SYNC_POL when row in [490, 491]; ~SYNC_POL otherwise
- Delay line: vid, hs and vs each pass through PIPE_DLY registers clocked every clk, not gated by pix_en. With PIPE_DLY = 0 the outputs equal the undelayed flags.
- frame_tick = 1 for exactly one clk, in the cycle where the counters become (0,0) by wrap. It is not delayed and is not asserted out of reset.
- All counter widths are 10 bits. Compares are unsigned. The porch/sync boundaries are computed from the parameters; the values above are the defaults.

## Timing
- Reset values (in the cycle after reset is sampled high):
  - div_cnt = 0, pix_col = 0, pix_row = 0, pix_en = 0, frame_tick = 0
  - video_on = 0
  - horiz_sync = vert_sync = ~SYNC_POL
  - every delay stage cleared to these same inactive values
- Reset asserted mid-frame aborts the scan. The first pix_en after release occurs CLK_DIV clocks after the first non-reset cycle.
- The counter update lands 1 clk after the pix_en strobe.
- One line = H_TOTAL*CLK_DIV = 3200 clk. One frame = 525*3200 = 1,680,000 clk. frame_tick period is 1,680,000 clk.
- video_on relative to pix_col/pix_row: latency PIPE_DLY clk. The first visible pixel after a frame wrap raises video_on PIPE_DLY clk after frame_tick.
- Simultaneous column and row wrap at (799,524) -> (0,0) in a single clk. No intermediate (0,524) is ever visible.

## Test plan
- Reset: hold reset 5 clk mid-line at (300,200), release. Required: pix_col/pix_row = 0, video_on = 0, syncs = 1. First pix_en 4 clk after release.
- Line timing, defaults: horiz_sync low for exactly 96*4 = 384 clk per line, falling when pix_col goes 655 -> 656. video_on high for 2560 clk of every 3200-clk line during rows 0..479.
- Frame timing: vert_sync low for exactly 2 lines (6400 clk), during rows 490-491. frame_tick period = 1,680,000 clk, with exactly one pulse per frame.
- Wrap: at (799,524) with pix_en, the next clk shows (0,0) and frame_tick = 1. Row never reads 525; column never reads 800.
- PIPE_DLY sweep 0..4: the video_on rising edge trails pix_col = 0/row = 0 by exactly PIPE_DLY clk. Sync edges shift by the same amount.
- CLK_DIV = 1, SYNC_POL = 1: pix_en constantly high, line = 800 clk, horiz_sync high for cols 656-751.
